// File: rtl/up_down_monitor_pkg.sv
// up_down_pkg: shared FSM state encoding, dir codes, step classes and the
// registered pulse bundle used by the up/down counter monitor.
package up_down_pkg;

  localparam int unsigned DIR_W = 2;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_IDLE = 2'b00;
  localparam dir_t DIR_UP   = 2'b01;
  localparam dir_t DIR_DOWN = 2'b10;

  // INIT means no previous sample has been captured yet.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } state_e;

  // Classification of the modular difference between two samples.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_JUMP = 2'd3
  } step_e;

  typedef struct packed {
    logic step_up;
    logic step_dn;
    logic wrap;
    logic jump;
    logic reversal;
  } pulse_t;

  // INIT and IDLE both report idle.
  function automatic dir_t dir_of(input state_e s);
    case (s)
      ST_UP:   dir_of = DIR_UP;
      ST_DOWN: dir_of = DIR_DOWN;
      default: dir_of = DIR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/up_down_monitor_if.sv
// up_down_monitor_if: observed count input and tracking/statistics outputs.
//   master: drives ct/valid/clr, receives dir, pulses and counters
//   slave : the monitor side
interface up_down_monitor_if
  import up_down_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8
);

  logic [W-1:0]  ct;
  logic          valid;
  logic          clr;
  dir_t          dir;
  logic          step_up;
  logic          step_dn;
  logic          wrap;
  logic          jump;
  logic          reversal;
  logic [CW-1:0] run_len;
  logic [CW-1:0] up_cnt;
  logic [CW-1:0] dn_cnt;

  modport master (
    output ct, valid, clr,
    input  dir, step_up, step_dn, wrap, jump, reversal, run_len, up_cnt, dn_cnt
  );

  modport slave (
    input  ct, valid, clr,
    output dir, step_up, step_dn, wrap, jump, reversal, run_len, up_cnt, dn_cnt
  );

endinterface

// File: rtl/up_down_monitor_sat_counter.sv
// sat_counter: registered counter with sync clear, load and saturating
// increment (priority clr > ld > inc).
//   clk, rst   : clock, async active-low reset
//   clr        : synchronous zero
//   ld, ld_val : synchronous load
//   inc        : increment, holds at all-ones
//   cnt        : registered count
module sat_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/up_down_monitor.sv
// up_down_monitor: watches samples from an up/down counter, tracks its
// direction, flags +1/-1 steps, wrap-around, loads (jumps) and reversals,
// and keeps run-length and saturating step statistics. Latency 1.
//   clk : rising-edge clock
//   rst : async active-low reset
//   mon : slave side of up_down_monitor_if (ct/valid/clr in, status out)
module up_down_monitor
  import up_down_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8
) (
  input  logic           clk,
  input  logic           rst,
  up_down_monitor_if.slave mon
);

  state_e        state_q;
  state_e        state_d;
  logic [W-1:0]  prev_q;
  logic [W-1:0]  prev_d;
  pulse_t        pulse_q;
  pulse_t        pulse_d;
  dir_t          dir_q;

  logic [W-1:0]  delta;
  step_e         step;

  logic          cnt_clr;
  logic          up_inc;
  logic          dn_inc;
  logic          run_inc;
  logic          run_ld;
  logic [CW-1:0] run_ld_val;

  // Modular difference between the new sample and the previous one.
  always_comb begin
    delta = W'(mon.ct - prev_q);
    if (delta == '0) begin
      step = STEP_HOLD;
    end else if (delta == W'(1)) begin
      step = STEP_UP;
    end else if (delta == '1) begin
      step = STEP_DOWN;
    end else begin
      step = STEP_JUMP;
    end
  end

  // State, previous sample and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      prev_q  <= '0;
      pulse_q <= '0;
      dir_q   <= DIR_IDLE;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      dir_q   <= dir_of(state_d);
    end
  end

  // Next-state, pulse and counter-control logic.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    pulse_d    = '0;
    cnt_clr    = 1'b0;
    up_inc     = 1'b0;
    dn_inc     = 1'b0;
    run_inc    = 1'b0;
    run_ld     = 1'b0;
    run_ld_val = '0;

    if (mon.clr) begin
      state_d = ST_INIT;
      cnt_clr = 1'b1;
    end else if (mon.valid) begin
      prev_d = mon.ct;
      if (state_q == ST_INIT) begin
        state_d = ST_IDLE;
      end else begin
        case (step)
          STEP_UP: begin
            pulse_d.step_up  = 1'b1;
            pulse_d.wrap     = (prev_q == '1);
            pulse_d.reversal = (state_q == ST_DOWN);
            up_inc           = 1'b1;
            state_d          = ST_UP;
            // Continuing a run extends it; any other entry restarts at 1.
            if (state_q == ST_UP) begin
              run_inc = 1'b1;
            end else begin
              run_ld     = 1'b1;
              run_ld_val = CW'(1);
            end
          end
          STEP_DOWN: begin
            pulse_d.step_dn  = 1'b1;
            pulse_d.wrap     = (prev_q == '0);
            pulse_d.reversal = (state_q == ST_UP);
            dn_inc           = 1'b1;
            state_d          = ST_DOWN;
            if (state_q == ST_DOWN) begin
              run_inc = 1'b1;
            end else begin
              run_ld     = 1'b1;
              run_ld_val = CW'(1);
            end
          end
          STEP_JUMP: begin
            pulse_d.jump = 1'b1;
            state_d      = ST_IDLE;
            run_ld       = 1'b1;
            run_ld_val   = '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  sat_counter #(.CW(CW)) u_run_len (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .ld     (run_ld),
    .ld_val (run_ld_val),
    .inc    (run_inc),
    .cnt    (mon.run_len)
  );

  sat_counter #(.CW(CW)) u_up_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (up_inc),
    .cnt    (mon.up_cnt)
  );

  sat_counter #(.CW(CW)) u_dn_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (dn_inc),
    .cnt    (mon.dn_cnt)
  );

  assign mon.dir      = dir_q;
  assign mon.step_up  = pulse_q.step_up;
  assign mon.step_dn  = pulse_q.step_dn;
  assign mon.wrap     = pulse_q.wrap;
  assign mon.jump     = pulse_q.jump;
  assign mon.reversal = pulse_q.reversal;

endmodule

// File: tb/tb_up_down_monitor.sv
// tb_up_down_monitor: table-driven directed vectors, hand sequences for
// saturation/clear/reset, and random stimulus against a behavioural model.
module tb_up_down_monitor;

  localparam int unsigned W   = 4;
  localparam int unsigned CW  = 8;
  localparam int          MOD = 1 << W;
  localparam int          SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  up_down_monitor_if #(.W(W), .CW(CW)) mon ();

  up_down_monitor #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: direction 0 idle, 1 up, 2 down.
  bit m_init;
  int m_prev, m_dir, m_run, m_up, m_dn;
  bit m_su, m_sd, m_wr, m_jp, m_rv;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model_reset();
    m_init = 1; m_prev = 0; m_dir = 0; m_run = 0; m_up = 0; m_dn = 0;
    m_su = 0; m_sd = 0; m_wr = 0; m_jp = 0; m_rv = 0;
  endtask

  task automatic model_step(input int c, input bit v, input bit cl);
    int d;
    m_su = 0; m_sd = 0; m_wr = 0; m_jp = 0; m_rv = 0;
    if (cl) begin
      m_init = 1; m_dir = 0; m_run = 0; m_up = 0; m_dn = 0;
    end else if (v) begin
      if (m_init) begin
        m_init = 0;
      end else begin
        d = (c - m_prev + MOD) % MOD;
        if (d == 1) begin
          m_su = 1; m_wr = (m_prev == MOD - 1); m_rv = (m_dir == 2);
          m_run = (m_dir == 1) ? sat(m_run + 1) : 1;
          m_dir = 1; m_up = sat(m_up + 1);
        end else if (d == MOD - 1) begin
          m_sd = 1; m_wr = (m_prev == 0); m_rv = (m_dir == 1);
          m_run = (m_dir == 2) ? sat(m_run + 1) : 1;
          m_dir = 2; m_dn = sat(m_dn + 1);
        end else if (d != 0) begin
          m_jp = 1; m_dir = 0; m_run = 0;
        end
      end
      m_prev = c;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dir"},      32'(mon.dir),      32'(m_dir));
    chk({tag, ".step_up"},  32'(mon.step_up),  32'(m_su));
    chk({tag, ".step_dn"},  32'(mon.step_dn),  32'(m_sd));
    chk({tag, ".wrap"},     32'(mon.wrap),     32'(m_wr));
    chk({tag, ".jump"},     32'(mon.jump),     32'(m_jp));
    chk({tag, ".reversal"}, 32'(mon.reversal), 32'(m_rv));
    chk({tag, ".run_len"},  32'(mon.run_len),  32'(m_run));
    chk({tag, ".up_cnt"},   32'(mon.up_cnt),   32'(m_up));
    chk({tag, ".dn_cnt"},   32'(mon.dn_cnt),   32'(m_dn));
  endtask

  // Apply one cycle of inputs and sample just after the clock edge.
  task automatic drive(input int c, input bit v, input bit cl);
    mon.ct    = W'(c);
    mon.valid = v;
    mon.clr   = cl;
    @(posedge clk);
    #1;
    model_step(c, v, cl);
  endtask

  typedef struct {
    int ct; bit valid; bit clr;
    int dir; bit su; bit sd; bit wr; bit jp; bit rv;
    int run; int up; int dn;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  initial begin
    //          ct v  c  dir su sd wr jp rv run up dn
    tbl[0]  = '{ 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // INIT capture
    tbl[1]  = '{ 4, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{ 5, 1, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0};
    tbl[3]  = '{ 6, 1, 0, 1, 1, 0, 0, 0, 0, 3, 3, 0};
    tbl[4]  = '{10, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0};  // load
    tbl[5]  = '{14, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0};
    tbl[6]  = '{15, 1, 0, 1, 1, 0, 0, 0, 0, 1, 4, 0};
    tbl[7]  = '{ 0, 1, 0, 1, 1, 0, 1, 0, 0, 2, 5, 0};  // 15->0 wrap
    tbl[8]  = '{15, 1, 0, 2, 0, 1, 1, 0, 1, 1, 5, 1};  // 0->15 wrap+rev
    tbl[9]  = '{ 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 5, 1};
    tbl[10] = '{ 7, 1, 0, 2, 0, 1, 0, 0, 0, 1, 5, 2};
    tbl[11] = '{ 7, 0, 0, 2, 0, 0, 0, 0, 0, 1, 5, 2};  // valid gap
    tbl[12] = '{ 7, 1, 0, 2, 0, 0, 0, 0, 0, 1, 5, 2};  // hold
    tbl[13] = '{ 9, 0, 0, 2, 0, 0, 0, 0, 0, 1, 5, 2};  // gap, ct ignored
    tbl[14] = '{ 6, 1, 0, 2, 0, 1, 0, 0, 0, 2, 5, 3};
    tbl[15] = '{ 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // clr beats valid
    tbl[16] = '{ 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};  // INIT capture
    tbl[17] = '{ 1, 1, 0, 2, 0, 1, 0, 0, 0, 1, 0, 1};
    tbl[18] = '{ 0, 1, 0, 2, 0, 1, 0, 0, 0, 2, 0, 2};
    tbl[19] = '{15, 1, 0, 2, 0, 1, 1, 0, 0, 3, 0, 3};  // 0->15 wrap

    rst = 1'b0;
    mon.ct = '0; mon.valid = 1'b0; mon.clr = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string t;
      drive(tbl[i].ct, tbl[i].valid, tbl[i].clr);
      t = $sformatf("vec%0d", i);
      chk({t, ".dir"},      32'(mon.dir),      32'(tbl[i].dir));
      chk({t, ".step_up"},  32'(mon.step_up),  32'(tbl[i].su));
      chk({t, ".step_dn"},  32'(mon.step_dn),  32'(tbl[i].sd));
      chk({t, ".wrap"},     32'(mon.wrap),     32'(tbl[i].wr));
      chk({t, ".jump"},     32'(mon.jump),     32'(tbl[i].jp));
      chk({t, ".reversal"}, 32'(mon.reversal), 32'(tbl[i].rv));
      chk({t, ".run_len"},  32'(mon.run_len),  32'(tbl[i].run));
      chk({t, ".up_cnt"},   32'(mon.up_cnt),   32'(tbl[i].up));
      chk({t, ".dn_cnt"},   32'(mon.dn_cnt),   32'(tbl[i].dn));
    end

    // Saturation: 300 consecutive up steps after a fresh capture.
    drive(0, 1, 1);
    drive(0, 1, 0);
    for (int i = 1; i <= 300; i++) drive(i % MOD, 1, 0);
    chk("sat.up_cnt",  32'(mon.up_cnt),  32'(SAT));
    chk("sat.run_len", 32'(mon.run_len), 32'(SAT));
    chk("sat.step_up", 32'(mon.step_up), 32'd1);
    chk("sat.dir",     32'(mon.dir),     32'd1);
    check_model("sat");

    // Clear together with valid.
    drive(5, 1, 1);
    chk("clr.up_cnt",  32'(mon.up_cnt),  32'd0);
    chk("clr.run_len", 32'(mon.run_len), 32'd0);
    chk("clr.step_up", 32'(mon.step_up), 32'd0);
    check_model("clr");
    drive(7, 1, 0);
    check_model("clr_capture");

    // Asynchronous reset in the middle of an up run.
    drive(8, 1, 0);
    drive(9, 1, 0);
    check_model("pre_rst");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(10, 1, 0);
    chk("post_rst.step_up", 32'(mon.step_up), 32'd0);
    check_model("post_rst");
    drive(11, 1, 0);
    chk("post_rst2.run_len", 32'(mon.run_len), 32'd1);
    check_model("post_rst2");

    // Random stimulus biased toward +/-1 steps.
    for (int i = 0; i < 600; i++) begin
      int r, c;
      bit v, cl;
      v  = ($urandom % 5) != 0;
      cl = ($urandom % 40) == 0;
      r  = int'($urandom % 5);
      if (r < 2)       c = (m_prev + 1) % MOD;
      else if (r == 2) c = (m_prev + MOD - 1) % MOD;
      else if (r == 3) c = m_prev;
      else             c = int'($urandom % MOD);
      drive(c, v, cl);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/up_down_monitor.md
UP_DOWN_MONITOR -- requirements
Module: up_down_monitor

Interface
REQ-001 SHALL have parameter W, default 4, meaning the width of the observed count.
REQ-002 SHALL have parameter CW, default 8, meaning the width of the statistics and run-length counters.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ct  input  W  count value observed from an up/down counter.
REQ-006 SHALL have port valid  input  1  ct is sampled this cycle when high.
REQ-007 SHALL have port clr  input  1  synchronous clear of tracking state and statistics.
REQ-008 SHALL have port dir  output  2  tracked direction: 00 idle, 01 up, 10 down.
REQ-009 SHALL have port step_up  output  1  one-cycle pulse on a +1 step.
REQ-010 SHALL have port step_dn  output  1  one-cycle pulse on a -1 step.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on a 2^W-1->0 or 0->2^W-1 step.
REQ-012 SHALL have port jump  output  1  one-cycle pulse on a non-adjacent, non-equal change (load detected).
REQ-013 SHALL have port reversal  output  1  one-cycle pulse on a direct up->down or down->up change.
REQ-014 SHALL have port run_len  output  CW  consecutive steps in the current direction.
REQ-015 SHALL have port up_cnt  output  CW  total +1 steps, saturating.
REQ-016 SHALL have port dn_cnt  output  CW  total -1 steps, saturating.

Function
REQ-017 SHALL run an FSM with states INIT (no prior sample), IDLE, UP and DOWN, and SHALL encode dir as 00 in INIT and IDLE.
REQ-018 SHALL, in INIT with valid=1, store ct as prev, go to IDLE, and emit no pulses.
REQ-019 SHALL, outside INIT with valid=1, compute delta = (ct - prev) mod 2^W and store ct as prev.
REQ-020 SHALL classify delta 0 as hold, 1 as up, 2^W-1 as down, and any other value as jump.
REQ-021 SHALL, on up, pulse step_up, go to UP, and increment up_cnt saturating at 2^CW-1.
REQ-022 SHALL, on down, pulse step_dn, go to DOWN, and increment dn_cnt saturating at 2^CW-1.
REQ-023 SHALL pulse wrap on up when prev=2^W-1, or on down when prev=0, in the same cycle as the step pulse.
REQ-024 SHALL, on jump, pulse jump, go to IDLE, and set run_len to 0.
REQ-025 SHALL, on hold, emit no pulses and leave state and run_len unchanged.
REQ-026 SHALL, on up in UP or down in DOWN, increment run_len saturating at 2^CW-1; on any other transition into UP or DOWN it SHALL load run_len with 1.
REQ-027 SHALL pulse reversal on UP->DOWN or DOWN->UP transitions only, not on IDLE->UP or IDLE->DOWN.
REQ-028 SHALL register all outputs so pulses appear the cycle after the valid sample is accepted (latency 1).
REQ-029 SHALL, when valid=0, hold all state and emit no pulses.
REQ-030 SHALL, when clr=1, go to INIT and zero run_len, up_cnt, dn_cnt and all pulses next cycle; clr takes priority over valid.

Reset
REQ-031 SHALL, while rst=0, asynchronously force INIT, prev=0, dir=00, all pulses 0, and run_len, up_cnt, dn_cnt to 0.
REQ-032 SHALL make the first valid sample after rst deasserts behave as an INIT capture, even if reset was asserted mid-run.

Structure
REQ-033 SHALL place the FSM state encoding and dir codes in a shared package, up_down_pkg.
REQ-034 SHALL implement the saturating counter as one reusable sub-module, sat_counter, instanced three times.

Verification
REQ-035 SHALL verify: reset, then ct 3,4,5,6 with valid=1 -> step_up x3, dir=01, run_len=3, up_cnt=3.
REQ-036 SHALL verify: ct 14,15,0 -> step_up x2, wrap alongside the 15->0 step; then 0->15 -> step_dn, wrap, reversal.
REQ-037 SHALL verify: after counting up to 6, ct=10 (load) -> jump, dir=00, run_len=0, no step pulse.
REQ-038 SHALL verify: ct 8,7,7,6 with valid gaps -> step_dn x2, no pulse on the hold or on valid=0 cycles, run_len=2.
REQ-039 SHALL verify: 300 consecutive up steps -> up_cnt and run_len saturate at 255; clr together with valid -> INIT, counters 0.
REQ-040 SHALL verify: rst asserted mid-count -> outputs are 0 immediately, and the next sample produces no pulse.
